// File: rtl/addsub_pkg.sv
// Shared definitions for the DE10-Lite adder/subtractor control stage:
// default operand width and the FSM states, encoded as they appear on LEDR.
package addsub_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] LED_WAIT_A = 2'b00;
   localparam logic [1:0] LED_WAIT_B = 2'b01;
   localparam logic [1:0] LED_CALC   = 2'b10;
   localparam logic [1:0] LED_SHOW   = 2'b11;

   typedef enum logic [1:0] {
      WAIT_A = LED_WAIT_A,
      WAIT_B = LED_WAIT_B,
      CALC   = LED_CALC,
      SHOW   = LED_SHOW
   } state_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces the active-low pushbutton and emits a one-cycle
// pulse on each accepted press (accepted level 1 -> 0).
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          accepted;
   logic          armed;
   logic [CW-1:0] count;

   // armed stays low until the key has been seen released after reset, so a key
   // held through reset deassertion can never produce a press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         accepted <= 1'b1;
         armed    <= 1'b0;
         count    <= '0;
         press    <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         armed <= armed | sync2;
         press <= 1'b0;
         if (sync2 == accepted) begin
            count <= '0;
         end else if (count == LAST_COUNT) begin
            count    <= '0;
            accepted <= sync2;
            press    <= armed & accepted & ~sync2;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/addsub_operand_sequencer.sv
// Operator-facing sequencer: captures A, then B and the operation on successive
// debounced key presses, and holds a registered sign/magnitude/carry result.
module addsub_operand_sequencer
   import addsub_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_n,
   input  logic [WIDTH-1:0] sw_operand,
   input  logic             sw_sub,
   output logic [WIDTH-1:0] result_mag,
   output logic             result_neg,
   output logic             carry_out,
   output logic             result_valid,
   output logic [1:0]       led_state
);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             op_sub;
   logic             press;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff_ab;
   logic [WIDTH-1:0] diff_ba;
   logic             a_lt_b;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .press(press)
   );

   // Subtraction is reported as sign plus magnitude, never as a wrapped value.
   assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
   assign diff_ab = a_reg - b_reg;
   assign diff_ba = b_reg - a_reg;
   assign a_lt_b  = (a_reg < b_reg);

   assign led_state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= WAIT_A;
         a_reg        <= '0;
         b_reg        <= '0;
         op_sub       <= 1'b0;
         result_mag   <= '0;
         result_neg   <= 1'b0;
         carry_out    <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            WAIT_A: begin
               if (press) begin
                  a_reg <= sw_operand;
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (press) begin
                  b_reg  <= sw_operand;
                  op_sub <= sw_sub;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (op_sub) begin
                  result_mag <= a_lt_b ? diff_ba : diff_ab;
                  result_neg <= a_lt_b;
                  carry_out  <= 1'b0;
               end else begin
                  result_mag <= sum[WIDTH-1:0];
                  result_neg <= 1'b0;
                  carry_out  <= sum[WIDTH];
               end
               result_valid <= 1'b1;
               state        <= SHOW;
            end
            SHOW: begin
               if (press) begin
                  result_valid <= 1'b0;
                  state        <= WAIT_A;
               end
            end
            default: state <= WAIT_A;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Self-checking bench for addsub_operand_sequencer with a short debounce window:
// directed table vectors, randomized operations against an arithmetic model, and reset/bounce sequences.
module tb_addsub_operand_sequencer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             key_n;
   logic [WIDTH-1:0] sw_operand;
   logic             sw_sub;
   logic [WIDTH-1:0] result_mag;
   logic             result_neg;
   logic             carry_out;
   logic             result_valid;
   logic [1:0]       led_state;

   int testsRun   = 0;
   int testsFailed = 0;

   typedef struct {
      int a;
      int b;
      int sub;
      int mag;
      int neg;
      int carry;
   } vec_t;

   vec_t vecs[5];

   addsub_operand_sequencer #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .sw_operand  (sw_operand),
      .sw_sub      (sw_sub),
      .result_mag  (result_mag),
      .result_neg  (result_neg),
      .carry_out   (carry_out),
      .result_valid(result_valid),
      .led_state   (led_state)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int operand, input int sub);
      sw_operand = operand[WIDTH-1:0];
      sw_sub     = sub[0];
   endtask

   // Arithmetic model: plain integer sum or signed difference.
   function automatic void refModel(input int a, input int b, input int sub,
                                    output int mag, output int neg, output int carry);
      int d;
      if (sub != 0) begin
         d     = a - b;
         neg   = (d < 0) ? 1 : 0;
         mag   = (d < 0) ? -d : d;
         carry = 0;
      end else begin
         d     = a + b;
         mag   = d % (1 << WIDTH);
         carry = d / (1 << WIDTH);
         neg   = 0;
      end
   endfunction

   task automatic pressAndWait(input string name, input int target);
      bit found = 0;
      key_n = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (led_state == target[1:0]) found = 1;
      end
      checkOutput(name, int'(led_state), target);
   endtask

   task automatic releaseKey();
      key_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic doReset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic doOperation(input int a, input int b, input int sub,
                              input int expMag, input int expNeg, input int expCarry);
      applyStimulus(a, $urandom_range(1, 0));
      pressAndWait("press_a_state", 1);
      applyStimulus(a ^ 5, ~sub);
      releaseKey();
      applyStimulus(b, sub);
      pressAndWait("press_b_calc", 2);
      checkOutput("valid_in_calc", int'(result_valid), 0);
      applyStimulus(b ^ 10, ~sub);
      @(negedge clk);
      checkOutput("valid_latency", int'(result_valid), 1);
      checkOutput("state_show", int'(led_state), 3);
      checkOutput("result_mag", int'(result_mag), expMag);
      checkOutput("result_neg", int'(result_neg), expNeg);
      checkOutput("carry_out", int'(carry_out), expCarry);
      releaseKey();
      pressAndWait("press_show_state", 0);
      checkOutput("valid_clear", int'(result_valid), 0);
      checkOutput("mag_hold", int'(result_mag), expMag);
      releaseKey();
   endtask

   initial begin
      int transitions;
      int prevState;
      int rm, rn, rc;
      int ra, rb, rs;

      vecs[0] = '{a: 9,  b: 8,  sub: 0, mag: 1,  neg: 0, carry: 1};
      vecs[1] = '{a: 3,  b: 12, sub: 1, mag: 9,  neg: 1, carry: 0};
      vecs[2] = '{a: 7,  b: 7,  sub: 1, mag: 0,  neg: 0, carry: 0};
      vecs[3] = '{a: 15, b: 15, sub: 0, mag: 14, neg: 0, carry: 1};
      vecs[4] = '{a: 12, b: 3,  sub: 1, mag: 9,  neg: 0, carry: 0};

      rst_n = 1'b0;
      key_n = 1'b1;
      applyStimulus(0, 0);
      repeat (3) @(negedge clk);
      checkOutput("reset_state", int'(led_state), 0);
      checkOutput("reset_mag", int'(result_mag), 0);
      checkOutput("reset_valid", int'(result_valid), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Short bounce must be ignored; a long hold gives exactly one press.
      key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("bounce_ignored", int'(led_state), 0);

      transitions = 0;
      prevState   = int'(led_state);
      key_n = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i == 20) key_n = 1'b1;
         @(negedge clk);
         if (int'(led_state) != prevState) transitions++;
         prevState = int'(led_state);
      end
      checkOutput("long_press_state", int'(led_state), 1);
      checkOutput("long_press_count", transitions, 1);
      doReset(2);

      for (int i = 0; i < 5; i++) begin
         doOperation(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].mag, vecs[i].neg, vecs[i].carry);
      end

      for (int i = 0; i < 8; i++) begin
         ra = int'($urandom_range(15, 0));
         rb = int'($urandom_range(15, 0));
         rs = int'($urandom_range(1, 0));
         refModel(ra, rb, rs, rm, rn, rc);
         doOperation(ra, rb, rs, rm, rn, rc);
      end

      // Reset from SHOW with the key held low through reset release.
      applyStimulus(6, 0);
      pressAndWait("pre_reset_a", 1);
      releaseKey();
      applyStimulus(13, 0);
      pressAndWait("pre_reset_b", 2);
      @(negedge clk);
      releaseKey();
      key_n = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_show_state", int'(led_state), 0);
      checkOutput("rst_show_mag", int'(result_mag), 0);
      checkOutput("rst_show_neg", int'(result_neg), 0);
      checkOutput("rst_show_carry", int'(carry_out), 0);
      checkOutput("rst_show_valid", int'(result_valid), 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("held_key_no_press", int'(led_state), 0);
      releaseKey();

      // Reset while waiting for B, then a fresh sequence.
      applyStimulus(5, 0);
      pressAndWait("midop_a", 1);
      releaseKey();
      doReset(2);
      checkOutput("midop_state", int'(led_state), 0);
      checkOutput("midop_valid", int'(result_valid), 0);
      doOperation(2, 1, 1, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
